spi_tx_mmio_writer: RTL
=======================

Name: spi_tx_mmio_writer

Overview:
- Memory-mapped front end that sits between the CPU store path and the SPI transmit controller.
- The CPU writes 32-bit words and control settings. The block queues the words and serialises each one into 1–4 bytes.
- Each byte is presented as a one-cycle `interrupt` pulse with `value`, which is exactly the push interface the SPI controller consumes.
- Bytes are rate-limited by a programmable gap so the SPI-side FIFO, which has no backpressure, is not overrun.

Parameters:
- BASE_ADDR, 32'hFFFF_0100, byte address of register 0. Registers are word-aligned at +0, +4, +8.
- WQ_DEPTH, 4, word queue depth. Power of two, at least 2.
- GAP_RESET, 16, reset value of the inter-byte gap, in clk cycles.

Ports:
- clk  in  1  CPU clock.
- rst_n  in  1  async active-low reset.
- mem_we  in  1  store strobe, one cycle per store.
- mem_re  in  1  load strobe.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  store data.
- mem_rdata  out  32  load data, combinational from registers. Zero when not addressed.
- interrupt  out  1  byte-valid pulse to the SPI controller, registered.
- value  out  8  byte to the SPI controller, registered. Meaningful only while `interrupt` is 1.

Behaviour:
- Reset: asynchronous, active-low. `interrupt`=0, `value`=0, queue empty, FSM IDLE, CTRL.len=3, CTRL.msb_first=1, GAP=GAP_RESET, overflow=0. Reset asserted mid-byte kills the pulse immediately; no partial word is resumed.
- Register map, decoded on mem_addr[31:2], so low 2 bits are ignored:
  - +0 DATA (write-only; reads 0). A store pushes {mem_wdata, CTRL.len, CTRL.msb_first} into the queue. The CTRL fields are snapshotted at push time.
  - +4 CTRL (rw). [1:0] len = bytes per word minus 1. [2] msb_first. [15:8] GAP in cycles; 0 is treated as 1.
  - +8 STATUS. Read fields:
    - [0] busy = queue not empty or FSM not IDLE.
    - [15:8] queue level, zero-extended.
    - [16] overflow, sticky.
  - STATUS write: writing 1 to bit 16 clears overflow. All other STATUS bits ignore writes.
- Queue: circular buffer with an extra wrap bit on each pointer; full/empty are decided from pointer equality plus the wrap bits.
  - A push on a full queue with no pop in the same cycle is dropped and sets overflow.
  - A push and a pop in the same cycle on a full queue are both accepted; the level stays unchanged.
  - A push while empty and idle is popped no earlier than the next cycle; there is no same-cycle bypass.
- Serialiser FSM states:
  - IDLE: if the queue is not empty, pop the head into a shift register and a byte counter, then go to EMIT.
  - EMIT: drive `interrupt`=1 for exactly one cycle with the current byte, then go to GAP. Byte order:
    - msb_first=1: byte 0 = word[8*len+7 : 8*len], descending to word[7:0].
    - msb_first=0: byte 0 = word[7:0], ascending.
  - GAP: count GAP-1 cycles. Then:
    - if bytes remain, go to EMIT with the next byte;
    - otherwise go to IDLE, where the next pop can occur the following cycle.
- Timing:
  - Byte-to-byte pulse spacing within a word is exactly GAP cycles.
  - Between words it is GAP+1 cycles (one IDLE cycle).
  - Latency: a DATA store at cycle T, queue empty and FSM IDLE, gives pop at T+1 and `interrupt` high at T+2.
- `interrupt` is never high on two consecutive cycles. `value` holds its last byte when `interrupt` is 0.
- CTRL writes take effect for the next pushed word only. A GAP change applies from the next GAP state entry.
- Simultaneous store and load to different registers are both honoured; reads see pre-write values.

Decomposition:
- Shared package `spi_mmio_pkg` holds:
  - register offsets (REG_DATA=0, REG_CTRL=1, REG_STATUS=2, as word indices);
  - FSM state enum {S_IDLE, S_EMIT, S_GAP};
  - CTRL and STATUS bit-position constants;
  - the queue entry typedef {data[31:0], len[1:0], msb_first}.
- One natural sub-module: `spi_word_fifo`, a WQ_DEPTH x 35-bit synchronous FIFO with push/pop/full/empty/level. It is reused later for the receive path.

Test Plan:
- Reset, then store DATA=32'hA1B2C3D4 with default CTRL -> `interrupt` pulses at T+2, T+18, T+34, T+50 with values A1, B2, C3, D4. STATUS.busy reads 0 from T+66.
- CTRL={GAP=4, msb_first=0, len=1}, then store 32'h0000_BEEF -> two pulses 4 cycles apart with values EF then BE. No further pulses.
- Five back-to-back DATA stores with WQ_DEPTH=4 and GAP=200 -> the first is popped, so 4 are queued and no overflow. A sixth store sets STATUS[16]=1, and writing 1 to bit 16 clears it.
- Queue full with a store landing in the same cycle as a pop -> level stays 4, overflow stays 0, and all 5 words are emitted in order.
- Deassert rst_n during the GAP state of the second byte -> `interrupt`=0 and the queue is empty immediately. After release, CTRL reads len=3, msb_first=1, GAP=16, and nothing is emitted.
- Load from STATUS during active emission with 2 words queued -> mem_rdata[0]=1 and [15:8]=2. Load from an unmapped address -> 0.

Source files
------------

// File: rtl/spi_mmio_pkg.sv
// Shared definitions for the SPI transmit MMIO front end: register word
// offsets, control/status bit positions, serialiser states and the
// word-queue entry layout.
package spi_mmio_pkg;

  // Register word indices relative to the block's base address
  localparam logic [29:0] REG_DATA   = 30'd0;
  localparam logic [29:0] REG_CTRL   = 30'd1;
  localparam logic [29:0] REG_STATUS = 30'd2;

  // CTRL field positions
  localparam int unsigned CTRL_LEN_LSB = 0;
  localparam int unsigned CTRL_MSB_BIT = 2;
  localparam int unsigned CTRL_GAP_LSB = 8;

  // STATUS field positions
  localparam int unsigned STAT_BUSY_BIT  = 0;
  localparam int unsigned STAT_LEVEL_LSB = 8;
  localparam int unsigned STAT_OVF_BIT   = 16;

  // Serialiser states
  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_GAP
  } state_e;

  // One queued word together with the CTRL settings captured at push time
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  len;
    logic        msb_first;
  } wq_entry_t;

  localparam int unsigned WQ_ENTRY_W = $bits(wq_entry_t);

  // The shift register is kept normalised so the next byte to send always
  // sits at the top (MSB-first) or the bottom (LSB-first) of the word.
  function automatic logic [7:0] head_byte(input logic [31:0] sh, input logic msb);
    return msb ? sh[31:24] : sh[7:0];
  endfunction

endpackage

// File: rtl/spi_word_fifo.sv
// Synchronous circular-buffer FIFO. Each pointer carries an extra wrap bit
// so full and empty can be told apart when the index bits are equal.
// The head entry is visible combinationally on data_o.
module spi_word_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 35
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wrPtr_q, wrPtr_d;
  logic [AW:0]      rdPtr_q, rdPtr_d;
  logic             pushOk;
  logic             popOk;

  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign level_o = wrPtr_q - rdPtr_q;
  assign data_o  = mem_q[rdPtr_q[AW-1:0]];

  // A push into a full queue is only accepted when the head leaves in the
  // same cycle, so the slot being overwritten is the one being popped.
  assign pushOk = push_i && (!full_o || pop_i);
  assign popOk  = pop_i && !empty_o;

  // Pointer advance for accepted pushes and pops
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (pushOk) begin
      wrPtr_d = wrPtr_q + {{AW{1'b0}}, 1'b1};
    end
    if (popOk) begin
      rdPtr_d = rdPtr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  // Pointer registers, cleared by reset so the queue comes up empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Storage array; contents need no reset because the pointers gate them
  always_ff @(posedge clk) begin
    if (pushOk) begin
      mem_q[wrPtr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/spi_tx_mmio_writer.sv
// CPU-facing register block that queues 32-bit words and serialises each
// into 1-4 bytes, presented to the SPI controller as one-cycle
// interrupt/value pulses separated by a programmable gap.
module spi_tx_mmio_writer
  import spi_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0100,
  parameter int unsigned WQ_DEPTH  = 4,
  parameter int unsigned GAP_RESET = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_we,
  input  logic        mem_re,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        interrupt,
  output logic [7:0]  value
);

  localparam int unsigned LVL_W  = $clog2(WQ_DEPTH) + 1;
  localparam logic [7:0]  GAP_RV = 8'(GAP_RESET);

  // Address decode
  logic [29:0] wordOff;
  logic        selData, selCtrl, selStatus;
  logic        unusedAddrBits;

  // Queue interface
  wq_entry_t        pushEntry, headEntry;
  logic             fifoFull, fifoEmpty;
  logic [LVL_W-1:0] fifoLevel;
  logic             push, pop;

  // Control / status registers
  logic [1:0] len_q, len_d;
  logic       msb_q, msb_d;
  logic [7:0] gap_q, gap_d;
  logic       ovf_q, ovf_d;

  // Serialiser state
  state_e      state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic        shMsb_q, shMsb_d;
  logic [1:0]  remain_q, remain_d;
  logic [7:0]  gapCnt_q, gapCnt_d;
  logic        int_q, int_d;
  logic [7:0]  value_q, value_d;

  // Helpers
  logic [7:0]  gapLoad;
  logic [1:0]  padBytes;
  logic [4:0]  padBits;
  logic [31:0] headNorm;
  logic        busy;

  assign wordOff        = mem_addr[31:2] - BASE_ADDR[31:2];
  assign selData        = (wordOff == REG_DATA);
  assign selCtrl        = (wordOff == REG_CTRL);
  assign selStatus      = (wordOff == REG_STATUS);
  assign unusedAddrBits = ^mem_addr[1:0];

  assign push      = mem_we && selData;
  assign pushEntry = '{data: mem_wdata, len: len_q, msb_first: msb_q};
  assign busy      = !fifoEmpty || (state_q != S_IDLE);

  spi_word_fifo #(
    .DEPTH (WQ_DEPTH),
    .WIDTH (WQ_ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (pushEntry),
    .pop_i   (pop),
    .data_o  (headEntry),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .level_o (fifoLevel)
  );

  // CTRL updates from stores and sticky overflow set/clear
  always_comb begin
    len_d = len_q;
    msb_d = msb_q;
    gap_d = gap_q;
    ovf_d = ovf_q;
    if (mem_we && selCtrl) begin
      len_d = mem_wdata[CTRL_LEN_LSB +: 2];
      msb_d = mem_wdata[CTRL_MSB_BIT];
      gap_d = mem_wdata[CTRL_GAP_LSB +: 8];
    end
    if (push && fifoFull && !pop) begin
      ovf_d = 1'b1;
    end
    if (mem_we && selStatus && mem_wdata[STAT_OVF_BIT]) begin
      ovf_d = 1'b0;
    end
  end

  // Load data mux; reads see the register values before any same-cycle store
  always_comb begin
    mem_rdata = '0;
    if (mem_re) begin
      if (selCtrl) begin
        mem_rdata[CTRL_LEN_LSB +: 2] = len_q;
        mem_rdata[CTRL_MSB_BIT]      = msb_q;
        mem_rdata[CTRL_GAP_LSB +: 8] = gap_q;
      end else if (selStatus) begin
        mem_rdata[STAT_BUSY_BIT]       = busy;
        mem_rdata[STAT_LEVEL_LSB +: 8] = 8'(fifoLevel);
        mem_rdata[STAT_OVF_BIT]        = ovf_q;
      end
    end
  end

  // Cycles spent in the GAP state. A programmed gap of 0 or 1 still keeps
  // one GAP cycle after each pulse so interrupt never stays high twice.
  assign gapLoad = (gap_q < 8'd2) ? 8'd1 : (gap_q - 8'd1);

  // Align an MSB-first word so its first byte lands in bits [31:24]
  assign padBytes = 2'd3 - headEntry.len;
  assign padBits  = {padBytes, 3'b000};
  assign headNorm = headEntry.msb_first ? (headEntry.data << padBits) : headEntry.data;

  // Serialiser next-state logic; interrupt/value are prepared one cycle
  // ahead so the registered pulse coincides with the EMIT state
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    shMsb_d  = shMsb_q;
    remain_d = remain_q;
    gapCnt_d = gapCnt_q;
    int_d    = 1'b0;
    value_d  = value_q;
    pop      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifoEmpty) begin
          pop      = 1'b1;
          state_d  = S_EMIT;
          shift_d  = headNorm;
          shMsb_d  = headEntry.msb_first;
          remain_d = headEntry.len;
          int_d    = 1'b1;
          value_d  = head_byte(headNorm, headEntry.msb_first);
        end
      end
      S_EMIT: begin
        state_d  = S_GAP;
        gapCnt_d = gapLoad;
        shift_d  = shMsb_q ? (shift_q << 8) : (shift_q >> 8);
      end
      S_GAP: begin
        if (gapCnt_q <= 8'd1) begin
          if (remain_q != 2'd0) begin
            state_d  = S_EMIT;
            remain_d = remain_q - 2'd1;
            int_d    = 1'b1;
            value_d  = head_byte(shift_q, shMsb_q);
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gapCnt_d = gapCnt_q - 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and register file; reset aborts any word in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q    <= 2'd3;
      msb_q    <= 1'b1;
      gap_q    <= GAP_RV;
      ovf_q    <= 1'b0;
      state_q  <= S_IDLE;
      shift_q  <= '0;
      shMsb_q  <= 1'b0;
      remain_q <= '0;
      gapCnt_q <= '0;
      int_q    <= 1'b0;
      value_q  <= '0;
    end else begin
      len_q    <= len_d;
      msb_q    <= msb_d;
      gap_q    <= gap_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      shift_q  <= shift_d;
      shMsb_q  <= shMsb_d;
      remain_q <= remain_d;
      gapCnt_q <= gapCnt_d;
      int_q    <= int_d;
      value_q  <= value_d;
    end
  end

  assign interrupt = int_q;
  assign value     = value_q;

endmodule
